// File: rtl/cnn_frame_feeder_if.sv
// Pixel-stream handshake between the source FIFO, the frame feeder and the CNN top.
interface cnn_frame_feeder_if #(
  parameter int unsigned GS_BITS  = 8,
  parameter int unsigned BCD_BITS = 4,
  parameter int unsigned D_WIDTH  = 16
);
  logic                fifo_empty;
  logic [D_WIDTH-1:0]  fifo_dout;
  logic                fifo_rd_en;
  logic [GS_BITS-1:0]  pixel_o;
  logic                pixel_o_valid;
  logic [BCD_BITS-1:0] digit_i;
  logic                digit_i_valid;

  // Feeder side: pops the FIFO, drives pixels, receives the classified digit.
  modport master (
    input  fifo_empty, fifo_dout, digit_i, digit_i_valid,
    output fifo_rd_en, pixel_o, pixel_o_valid
  );

  // Environment side: the FIFO and the CNN top.
  modport slave (
    output fifo_empty, fifo_dout, digit_i, digit_i_valid,
    input  fifo_rd_en, pixel_o, pixel_o_valid
  );
endinterface

// File: rtl/cnn_frame_feeder.sv
// Frame feeder: streams IMG_DIM*IMG_DIM pixels per frame from a show-ahead FIFO into
// the CNN, waits for its digit, tags it with a frame index, and guards the handshake
// with a timeout watchdog and sticky error flags.
module cnn_frame_feeder #(
  parameter int unsigned GS_BITS        = 8,
  parameter int unsigned BCD_BITS       = 4,
  parameter int unsigned D_WIDTH        = 16,
  parameter int unsigned IMG_DIM        = 30,
  parameter int unsigned TIMEOUT_CYCLES = 65536,
  parameter int unsigned FRAME_BITS     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  clear_err,
  cnn_frame_feeder_if.master    bus,
  output logic [BCD_BITS-1:0]   result_digit,
  output logic [FRAME_BITS-1:0] result_frame,
  output logic                  result_valid,
  output logic                  busy,
  output logic                  timeout_err,
  output logic                  spurious_err
);

  localparam int unsigned PIX_N = IMG_DIM * IMG_DIM;
  localparam int unsigned PIX_W = (PIX_N > 1) ? $clog2(PIX_N) : 1;
  localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STREAM   = 2'd1,
    WAIT_RES = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [PIX_W-1:0]      pix_cnt_q, pix_cnt_d;
  logic [FRAME_BITS-1:0] frame_cnt_q, frame_cnt_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic [GS_BITS-1:0]    pixel_q, pixel_d;
  logic                  pixel_valid_q, pixel_valid_d;
  logic [BCD_BITS-1:0]   res_digit_q, res_digit_d;
  logic [FRAME_BITS-1:0] res_frame_q, res_frame_d;
  logic                  res_valid_q, res_valid_d;
  logic                  timeout_q, timeout_d;
  logic                  spurious_q, spurious_d;
  logic                  timeout_set, spurious_set;
  logic                  rd_en_c;

  // Only the low GS_BITS of the FIFO word carry pixel data.
  logic unused_dout;
  assign unused_dout = ^bus.fifo_dout;

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pix_cnt_q     <= '0;
      frame_cnt_q   <= '0;
      to_cnt_q      <= '0;
      pixel_q       <= '0;
      pixel_valid_q <= 1'b0;
      res_digit_q   <= '0;
      res_frame_q   <= '0;
      res_valid_q   <= 1'b0;
      timeout_q     <= 1'b0;
      spurious_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pix_cnt_q     <= pix_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      to_cnt_q      <= to_cnt_d;
      pixel_q       <= pixel_d;
      pixel_valid_q <= pixel_valid_d;
      res_digit_q   <= res_digit_d;
      res_frame_q   <= res_frame_d;
      res_valid_q   <= res_valid_d;
      timeout_q     <= timeout_d;
      spurious_q    <= spurious_d;
    end
  end

  // Next-state, FIFO pop strobe and error-flag update.
  always_comb begin
    state_d       = state_q;
    pix_cnt_d     = pix_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    to_cnt_d      = to_cnt_q;
    pixel_d       = pixel_q;
    pixel_valid_d = 1'b0;
    res_digit_d   = res_digit_q;
    res_frame_d   = res_frame_q;
    res_valid_d   = 1'b0;
    timeout_set   = 1'b0;
    spurious_set  = 1'b0;
    rd_en_c       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.digit_i_valid) spurious_set = 1'b1;
        if (run) state_d = STREAM;
      end

      STREAM: begin
        if (bus.digit_i_valid) spurious_set = 1'b1;
        rd_en_c = !bus.fifo_empty && run;
        if (rd_en_c) begin
          pixel_d       = bus.fifo_dout[GS_BITS-1:0];
          pixel_valid_d = 1'b1;
          if (pix_cnt_q == PIX_W'(PIX_N - 1)) begin
            // Last pixel of the frame: stop reading until the CNN answers.
            pix_cnt_d = '0;
            to_cnt_d  = '0;
            state_d   = WAIT_RES;
          end else begin
            pix_cnt_d = pix_cnt_q + PIX_W'(1);
          end
        end
      end

      WAIT_RES: begin
        if (bus.digit_i_valid) begin
          res_digit_d = bus.digit_i;
          res_frame_d = frame_cnt_q;
          res_valid_d = 1'b1;
          frame_cnt_d = frame_cnt_q + FRAME_BITS'(1);
          to_cnt_d    = '0;
          state_d     = run ? STREAM : IDLE;
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          // Abandon the frame; its index is still consumed.
          timeout_set = 1'b1;
          frame_cnt_d = frame_cnt_q + FRAME_BITS'(1);
          to_cnt_d    = '0;
          state_d     = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    // A new error event takes priority over a coincident clear.
    timeout_d  = (timeout_q  && !clear_err) || timeout_set;
    spurious_d = (spurious_q && !clear_err) || spurious_set;
  end

  assign bus.fifo_rd_en    = rd_en_c;
  assign bus.pixel_o       = pixel_q;
  assign bus.pixel_o_valid = pixel_valid_q;
  assign result_digit      = res_digit_q;
  assign result_frame      = res_frame_q;
  assign result_valid      = res_valid_q;
  assign busy              = (state_q != IDLE);
  assign timeout_err       = timeout_q;
  assign spurious_err      = spurious_q;

endmodule
